// File: rtl/fpu_issue_seq.sv
// Issue sequencer in front of pfpu32_top: accepts one op, pulses decode/execute,
// waits for the matching FPU valid (with watchdog abort) and returns the response.
module fpu_issue_seq #(
  parameter int OP_W    = 8,
  parameter int RM_W    = 2,
  parameter int CSR_W   = 11,
  parameter int TIMEOUT = 64,
  parameter int CMP_BIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [OP_W-1:0]  req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [RM_W-1:0]  req_rm_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_result_o,
  output logic             resp_cmp_o,
  output logic [CSR_W-1:0] resp_csr_o,
  output logic             resp_err_o,
  input  logic             flush_i,
  output logic             fpu_flush_o,
  output logic             fpu_decode_o,
  output logic             fpu_execute_o,
  output logic [OP_W-1:0]  fpu_op_o,
  output logic [31:0]      fpu_a_o,
  output logic [31:0]      fpu_b_o,
  output logic [RM_W-1:0]  fpu_rm_o,
  input  logic [31:0]      fpu_result_i,
  input  logic             fpu_arith_valid_i,
  input  logic             fpu_cmp_i,
  input  logic             fpu_cmp_valid_i,
  input  logic [CSR_W-1:0] fpu_csr_i
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WAIT, RESP} state_t;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_flush_q;
  logic            is_cmp;
  logic            fpu_done;

  assign is_cmp      = fpu_op_o[CMP_BIT];
  assign fpu_done    = is_cmp ? fpu_cmp_valid_i : fpu_arith_valid_i;
  assign fpu_flush_o = flush_i | wd_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      wd_flush_q    <= 1'b0;
      req_ready_o   <= 1'b0;
      resp_valid_o  <= 1'b0;
      resp_result_o <= '0;
      resp_cmp_o    <= 1'b0;
      resp_csr_o    <= '0;
      resp_err_o    <= 1'b0;
      fpu_decode_o  <= 1'b0;
      fpu_execute_o <= 1'b0;
      fpu_op_o      <= '0;
      fpu_a_o       <= '0;
      fpu_b_o       <= '0;
      fpu_rm_o      <= '0;
    end else begin
      fpu_decode_o  <= 1'b0;
      fpu_execute_o <= 1'b0;
      wd_flush_q    <= 1'b0;
      // External flush beats everything, including a request offered in IDLE.
      if (flush_i) begin
        state        <= IDLE;
        req_ready_o  <= 1'b1;
        resp_valid_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            req_ready_o <= 1'b1;
            if (req_valid_i && req_ready_o) begin
              fpu_op_o     <= req_op_i;
              fpu_a_o      <= req_a_i;
              fpu_b_o      <= req_b_i;
              fpu_rm_o     <= req_rm_i;
              wd_cnt       <= '0;
              req_ready_o  <= 1'b0;
              fpu_decode_o <= 1'b1;
              state        <= DECODE;
            end
          end
          DECODE: begin
            fpu_execute_o <= 1'b1;
            state         <= EXEC;
          end
          EXEC: begin
            state <= WAIT;
          end
          WAIT: begin
            wd_cnt <= wd_cnt + WD_W'(1);
            // A valid landing on the timeout cycle still counts as a normal completion.
            if (fpu_done) begin
              resp_result_o <= is_cmp ? 32'd0 : fpu_result_i;
              resp_cmp_o    <= is_cmp ? fpu_cmp_i : 1'b0;
              resp_csr_o    <= fpu_csr_i;
              resp_err_o    <= 1'b0;
              resp_valid_o  <= 1'b1;
              state         <= RESP;
            end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
              wd_flush_q    <= 1'b1;
              resp_result_o <= '0;
              resp_cmp_o    <= 1'b0;
              resp_csr_o    <= '0;
              resp_err_o    <= 1'b1;
              resp_valid_o  <= 1'b1;
              state         <= RESP;
            end
          end
          RESP: begin
            if (resp_ready_i) begin
              resp_valid_o <= 1'b0;
              req_ready_o  <= 1'b1;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
